// File: rtl/modulator_3lpwm.sv
// Level-shifted 3-level PWM for one leg: triangular carrier, shadowed reference, dwell-limited N/Z/P FSM.
// v_lev and sync lag the carrier count by one cycle; no backpressure, ce=0 freezes every register.
module modulator_3lpwm #(
  parameter int CW          = 16,
  parameter int RW          = 16,
  parameter int UPDATE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 en,
  input  logic [CW-1:0]        period,
  input  logic signed [RW-1:0] mod_ref,
  input  logic                 ref_valid,
  input  logic [7:0]           t_min,
  output logic [1:0]           v_lev,
  output logic                 sync,
  output logic                 lev_busy
);

  localparam logic [1:0] LV_N = 2'b00;
  localparam logic [1:0] LV_Z = 2'b01;
  localparam logic [1:0] LV_P = 2'b10;

  // Wide enough for |most-negative ref| and for P+1.
  localparam int MW = ((RW > CW + 1) ? RW : CW + 1) + 1;

  logic [CW-1:0]        cnt;
  logic                 dir_dn;
  logic signed [RW-1:0] ref_pend;
  logic signed [RW-1:0] ref_act;
  logic [CW-1:0]        per_pend;
  logic [CW-1:0]        per_act;
  logic [7:0]           dwell;
  logic [1:0]           state;

  logic [CW-1:0]        period_fix;
  logic [CW-1:0]        per_m1;
  logic                 valley;
  logic                 peak;
  logic                 load;
  logic [CW-1:0]        cnt_nx;
  logic                 dir_nx;

  logic signed [MW-1:0] ref_sx;
  logic [MW-1:0]        mag;
  logic [MW-1:0]        lim;
  logic [MW-1:0]        m_sat;
  logic [MW-1:0]        cnt_x;
  logic                 ref_pos;
  logic                 ref_neg;
  logic [1:0]           req;

  logic [7:0]           t_dw;
  logic [1:0]           state_nx;
  logic [7:0]           dwell_nx;

  assign period_fix = (period < CW'(2)) ? CW'(2) : period;
  assign per_m1     = per_act - CW'(1);
  assign valley     = !dir_dn && (cnt == '0);
  assign peak       = (cnt == per_act);
  assign load       = valley || ((UPDATE_MODE != 0) && peak);

  // Compares use >= / <= so a shrunken period at a peak load cannot overrun the turn points.
  always_comb begin
    cnt_nx = cnt;
    dir_nx = dir_dn;
    if (!dir_dn) begin
      if (cnt >= per_m1) begin
        cnt_nx = per_act;
        dir_nx = 1'b1;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end else begin
      if (cnt <= CW'(1)) begin
        cnt_nx = '0;
        dir_nx = 1'b0;
      end else begin
        cnt_nx = cnt - CW'(1);
      end
    end
  end

  assign ref_sx  = {{(MW-RW){ref_act[RW-1]}}, ref_act};
  assign mag     = ref_sx[MW-1] ? MW'(-ref_sx) : MW'(ref_sx);
  assign lim     = {{(MW-CW){1'b0}}, per_act} + MW'(1);
  assign m_sat   = (mag > lim) ? lim : mag;
  assign cnt_x   = {{(MW-CW){1'b0}}, cnt};
  assign ref_neg = ref_act[RW-1];
  assign ref_pos = !ref_act[RW-1] && (ref_act != '0);

  always_comb begin
    req = LV_Z;
    if (ref_pos && (m_sat > cnt_x)) begin
      req = LV_P;
    end else if (ref_neg && (m_sat > cnt_x)) begin
      req = LV_N;
    end
  end

  assign t_dw = (t_min == 8'd0) ? 8'd0 : t_min - 8'd1;

  // A P<->N request detours through Z so the leg decoder never sees a two-level jump.
  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    if (dwell != 8'd0) begin
      dwell_nx = dwell - 8'd1;
    end else if (req != state) begin
      dwell_nx = t_dw;
      if (((state == LV_P) && (req == LV_N)) || ((state == LV_N) && (req == LV_P))) begin
        state_nx = LV_Z;
      end else begin
        state_nx = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dir_dn   <= 1'b0;
      ref_pend <= '0;
      ref_act  <= '0;
      per_pend <= CW'(2);
      per_act  <= CW'(2);
      dwell    <= 8'd0;
      state    <= LV_Z;
      sync     <= 1'b0;
    end else if (ce) begin
      if (ref_valid) begin
        ref_pend <= mod_ref;
        per_pend <= period_fix;
      end
      if (!en) begin
        cnt    <= '0;
        dir_dn <= 1'b0;
        dwell  <= 8'd0;
        state  <= LV_Z;
        sync   <= 1'b0;
      end else begin
        cnt    <= cnt_nx;
        dir_dn <= dir_nx;
        dwell  <= dwell_nx;
        state  <= state_nx;
        sync   <= valley;
        if (load) begin
          ref_act <= ref_pend;
          per_act <= per_pend;
        end
      end
    end
  end

  assign v_lev    = state;
  assign lev_busy = (dwell != 8'd0);

endmodule

// File: tb/tb_modulator_3lpwm.sv
// Directed bench for modulator_3lpwm: per-period level census table plus hand-traced corner sequences.
module tb_modulator_3lpwm;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic               en;
  logic [15:0]        period;
  logic signed [15:0] mod_ref;
  logic               ref_valid;
  logic [7:0]         t_min;
  logic [1:0]         v_lev;
  logic               sync;
  logic               lev_busy;

  always #5 clk = ~clk;

  modulator_3lpwm #(.CW(16), .RW(16), .UPDATE_MODE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .en        (en),
    .period    (period),
    .mod_ref   (mod_ref),
    .ref_valid (ref_valid),
    .t_min     (t_min),
    .v_lev     (v_lev),
    .sync      (sync),
    .lev_busy  (lev_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int direct_steps = 0;
  logic [1:0] prev_lev = 2'b01;

  // Watches every cycle for a forbidden N<->P jump or the unused 2'b11 code.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (((prev_lev == 2'b00) && (v_lev == 2'b10)) ||
          ((prev_lev == 2'b10) && (v_lev == 2'b00)) || (v_lev == 2'b11))
        direct_steps++;
    end
    prev_lev = v_lev;
  end

  typedef struct {
    logic signed [15:0] ref_v;
    logic [15:0]        per;
    logic [7:0]         tmin;
    int                 n_p;
    int                 n_z;
    int                 n_n;
    int                 n_sync;
    int                 n_busy;
  } scn_t;

  scn_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench just after the first enabled edge (carrier position 0).
  task automatic start_scn(input logic signed [15:0] r, input logic [15:0] p, input logic [7:0] t);
    en        = 1'b0;
    ref_valid = 1'b1;
    mod_ref   = r;
    period    = p;
    t_min     = t;
    tick();
    ref_valid = 1'b0;
    chk("en0_vlev", 32'(v_lev), 32'd1);
    chk("en0_sync", 32'(sync), 32'd0);
    chk("en0_busy", 32'(lev_busy), 32'd0);
    en = 1'b1;
    tick();
  endtask

  initial begin
    int cp, cz, cn, cs, cb;
    rst       = 1'b0;
    ce        = 1'b1;
    en        = 1'b0;
    ref_valid = 1'b0;
    mod_ref   = '0;
    period    = 16'd10;
    t_min     = 8'd0;

    tbl[0]  = '{16'sd5,      16'd10, 8'd0, 9,  11, 0,  1, 0};
    tbl[1]  = '{-16'sd5,     16'd10, 8'd0, 0,  11, 9,  1, 0};
    tbl[2]  = '{16'sd1,      16'd10, 8'd3, 3,  17, 0,  1, 4};
    tbl[3]  = '{16'sd0,      16'd10, 8'd0, 0,  20, 0,  1, 0};
    tbl[4]  = '{16'sd32767,  16'd10, 8'd0, 20, 0,  0,  1, 0};
    tbl[5]  = '{16'sh8000,   16'd10, 8'd0, 0,  0,  20, 1, 0};
    tbl[6]  = '{16'sd10,     16'd10, 8'd0, 19, 1,  0,  1, 0};
    tbl[7]  = '{16'sd11,     16'd10, 8'd0, 20, 0,  0,  1, 0};
    tbl[8]  = '{16'sd5,      16'd10, 8'd4, 9,  11, 0,  1, 6};
    tbl[9]  = '{-16'sd1,     16'd10, 8'd0, 0,  19, 1,  1, 0};
    tbl[10] = '{16'sd1,      16'd0,  8'd0, 5,  15, 0,  5, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vlev", 32'(v_lev), 32'd1);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_busy", 32'(lev_busy), 32'd0);
    rst = 1'b1;
    tick();

    // One settling period, then a 20-cycle census window.
    for (int i = 0; i < 11; i++) begin
      start_scn(tbl[i].ref_v, tbl[i].per, tbl[i].tmin);
      repeat (19) tick();
      cp = 0; cz = 0; cn = 0; cs = 0; cb = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (v_lev == 2'b10) cp++;
        if (v_lev == 2'b01) cz++;
        if (v_lev == 2'b00) cn++;
        if (sync) cs++;
        if (lev_busy) cb++;
      end
      chk($sformatf("s%0d_p", i), 32'(cp), 32'(tbl[i].n_p));
      chk($sformatf("s%0d_z", i), 32'(cz), 32'(tbl[i].n_z));
      chk($sformatf("s%0d_n", i), 32'(cn), 32'(tbl[i].n_n));
      chk($sformatf("s%0d_sync", i), 32'(cs), 32'(tbl[i].n_sync));
      chk($sformatf("s%0d_busy", i), 32'(cb), 32'(tbl[i].n_busy));
    end

    // Reference flips sign mid-period: change lands at the valley via a single Z cycle.
    start_scn(-16'sd5, 16'd10, 8'd0);
    for (int j = 1; j <= 43; j++) begin
      tick();
      if (j == 25) begin
        ref_valid = 1'b1;
        mod_ref   = 16'sd5;
      end
      if (j == 26) ref_valid = 1'b0;
      if (j == 35) chk("flip_pre_vlev35", 32'(v_lev), 32'd1);
      if (j == 39) chk("flip_vlev39", 32'(v_lev), 32'd0);
      if (j == 40) begin
        chk("flip_vlev40", 32'(v_lev), 32'd0);
        chk("flip_sync40", 32'(sync), 32'd1);
      end
      if (j == 41) chk("flip_vlev41", 32'(v_lev), 32'd1);
      if (j == 42) chk("flip_vlev42", 32'(v_lev), 32'd2);
      if (j == 43) chk("flip_vlev43", 32'(v_lev), 32'd2);
    end

    // Clock-enable freeze at cnt=6 while the Z dwell is counting.
    start_scn(16'sd5, 16'd10, 8'd4);
    repeat (26) tick();
    chk("ce_pre_vlev", 32'(v_lev), 32'd1);
    chk("ce_pre_busy", 32'(lev_busy), 32'd1);
    ce = 1'b0;
    for (int f = 0; f < 5; f++) begin
      tick();
      chk("ce_hold_vlev", 32'(v_lev), 32'd1);
      chk("ce_hold_busy", 32'(lev_busy), 32'd1);
      chk("ce_hold_sync", 32'(sync), 32'd0);
    end
    ce = 1'b1;
    cs = 0;
    for (int m = 1; m <= 14; m++) begin
      tick();
      if (m == 1) chk("ce_res_busy1", 32'(lev_busy), 32'd1);
      if (m == 2) chk("ce_res_busy2", 32'(lev_busy), 32'd0);
      if (m < 14 && sync) cs++;
      if (m == 14) begin
        chk("ce_res_sync_early", 32'(cs), 32'd0);
        chk("ce_res_sync", 32'(sync), 32'd1);
        chk("ce_res_vlev", 32'(v_lev), 32'd2);
      end
    end

    // Asynchronous reset in mid-period with v_lev=P.
    start_scn(16'sd8, 16'd10, 8'd0);
    repeat (27) tick();
    chk("ar_pre_vlev", 32'(v_lev), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("ar_vlev", 32'(v_lev), 32'd1);
    chk("ar_sync", 32'(sync), 32'd0);
    chk("ar_busy", 32'(lev_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cz = 0; cs = 0;
    for (int m = 1; m <= 20; m++) begin
      tick();
      if (m == 1) chk("ar_first_sync", 32'(sync), 32'd1);
      if (v_lev == 2'b01) cz++;
      if (sync) cs++;
    end
    chk("ar_post_z", 32'(cz), 32'd20);
    chk("ar_post_sync_p2", 32'(cs), 32'd5);
    mod_ref   = 16'sd5;
    ref_valid = 1'b1;
    for (int m = 21; m <= 26; m++) begin
      tick();
      if (m == 21) begin
        ref_valid = 1'b0;
        chk("ar_load_sync21", 32'(sync), 32'd1);
      end
      if (m == 22) chk("ar_vlev22", 32'(v_lev), 32'd1);
      if (m == 25) begin
        chk("ar_sync25", 32'(sync), 32'd1);
        chk("ar_vlev25", 32'(v_lev), 32'd1);
      end
      if (m == 26) chk("ar_vlev26", 32'(v_lev), 32'd2);
    end

    chk("no_direct_np_step", 32'(direct_steps), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
